rca_pipelined: RTL and testbench
================================

// Module: rca_pipelined
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor for the datapath ALU.
//  Splits a WIDTH-bit add into STAGES carry-ripple segments, with carry registered between segments.
//  Accepts one operation per clock under a valid/ready handshake and produces sum, carry, overflow and zero flags.
//  Sits between the operand latch and the result writeback, replacing the fixed-width combinational adders.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits; must be a multiple of STAGES
//  STAGES   4  pipeline depth = number of carry segments, 1..WIDTH
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept an operand beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (add mode only)
//  sub        in   1      0: a+b+c_in; 1: a-b (a+~b+1, c_in ignored)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  c_out      out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB XOR c_out
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valid bits, out_valid, sum, c_out, ovf, zero -> 0; data regs -> 0.
//  - Global advance enable: adv = out_ready | ~out_valid; in_ready = adv (combinational).
//  - Beat accepted when in_valid & in_ready; a beat with in_valid=0 on adv inserts a bubble (valid=0).
//  - When adv=0 every stage register holds; no beat is lost or duplicated.
//  - Stage k (0..STAGES-1) adds segment k (SEG=WIDTH/STAGES bits) using carry registered by stage k-1
//    (stage 0 uses sub ? 1 : c_in); b segment pre-inverted when sub=1, sub bit travels with the beat.
//  - Unprocessed upper segments of a, b are skewed forward; finished lower sum segments are carried along,
//    so the output is aligned: full result appears on out_valid exactly STAGES accepted-cycles after input.
//  - Throughput 1 beat/cycle when out_ready held high; latency STAGES cycles (no combinational in->out path).
//  - ovf/zero computed in final stage from full sum and MSB carries; valid only while out_valid=1.
//  - Outputs hold stable while out_valid=1 & out_ready=0.
//  - STAGES=1: degenerates to one registered full-width ripple add, latency 1.
//  - Simultaneous accept and drain on a full pipeline: legal, both happen in the same cycle.
//  - Reset mid-operation: all in-flight beats discarded, next out_valid no earlier than STAGES cycles after release.
//  - Wrap-around: sum is modulo 2^WIDTH; c_out carries the lost bit, never saturates.
// STRUCTURE
//  - Shared header adder_defs.vh: default WIDTH/STAGES, SEG width macro, width-check macro.
//  - Sub-module rca_pipe_stage: combinational SEG-bit ripple segment (a, b, cin -> s, cout, cin_msb),
//    built from the team full adder; instantiated STAGES times in a generate loop.
//  - Top holds per-stage valid/sub/carry regs, skew and deskew register arrays, handshake logic, flag logic.
// TESTING (WIDTH=32, STAGES=4 unless noted)
//  1 Reset: hold rst_n=0 3 cycles with in_valid=1 -> out_valid=0, sum=0; after release first result at +4 cycles.
//  2 Carry ripple across all segments: a=FFFFFFFF, b=00000001, c_in=0 -> sum=00000000, c_out=1, zero=1, ovf=0.
//  3 Subtract/overflow: sub=1, a=80000000, b=00000001 -> sum=7FFFFFFF, c_out=1, ovf=1; a=5, b=7 -> FFFFFFFE, c_out=0.
//  4 Streaming: 100 back-to-back random beats, out_ready=1 -> one result per cycle, in order, matches a+b+c_in.
//  5 Backpressure: out_ready=0 for 6 cycles mid-stream -> in_ready=0 once full, outputs stable, no loss/dup.
//  6 Params: WIDTH=8, STAGES=1 and WIDTH=16, STAGES=16 -> exhaustive/random check vs reference, latency=STAGES.

Source files
------------

// File: rtl/rca_pipelined_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: default geometry,
// segment width helper, flag bundle and the single-bit full adder cell.
package rca_pipelined_pkg;

  localparam int RCA_DEF_WIDTH  = 32;
  localparam int RCA_DEF_STAGES = 4;

  // Result flags that travel alongside the final sum register.
  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
  } rca_flags_t;

  // Bits per carry segment; WIDTH is expected to divide evenly by STAGES.
  function automatic int rca_seg_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] rca_fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/rca_pipelined_stage.sv
// One combinational carry-ripple segment. Also exposes the carry into the
// segment MSB so the final stage can form the signed-overflow flag.
module rca_pipe_stage
  import rca_pipelined_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           cin_msb
);

  // Ripple the carry bit by bit through full adder cells.
  always_comb begin
    logic       c;
    logic [1:0] fa;
    c       = cin;
    s       = '0;
    cin_msb = cin;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) cin_msb = c;
      fa   = rca_fa(a[i], b[i], c);
      s[i] = fa[0];
      c    = fa[1];
    end
    cout = c;
  end

endmodule

// File: rtl/rca_pipelined.sv
// Pipelined ripple-carry adder/subtractor. Each stage adds one segment with
// the carry registered by the previous stage; upper operand segments are
// skewed forward and finished lower sum segments ride along, so the full
// aligned result appears STAGES accepted cycles after the operands.
module rca_pipelined
  import rca_pipelined_pkg::*;
#(
  parameter int WIDTH  = RCA_DEF_WIDTH,
  parameter int STAGES = RCA_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = rca_seg_w(WIDTH, STAGES);

  // Registers at the output of each stage.
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            sub_q, sub_d;
  logic [STAGES-1:0]            cy_q, cy_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
  rca_flags_t                   flg_q, flg_d;

  // Inputs presented to each stage (ports for stage 0, previous regs otherwise).
  logic [STAGES-1:0]            st_vld, st_sub, st_cin;
  logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_s;
  logic [STAGES-1:0][SEG-1:0]   seg_s;
  logic [STAGES-1:0]            seg_co, seg_cmsb;

  logic adv;
  logic unused_bits;

  // The whole pipe moves together; it only stalls when a result is stuck.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = flg_q.c_out;
  assign ovf       = flg_q.ovf;
  assign zero      = flg_q.zero;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // b is inverted once at entry; subtract forces the initial carry to 1.
      assign st_vld[k] = in_valid;
      assign st_sub[k] = sub;
      assign st_cin[k] = sub | c_in;
      assign st_a[k]   = a;
      assign st_b[k]   = sub ? ~b : b;
      assign st_s[k]   = '0;
    end else begin : g_body
      assign st_vld[k] = vld_q[k-1];
      assign st_sub[k] = sub_q[k-1];
      assign st_cin[k] = cy_q[k-1];
      assign st_a[k]   = a_q[k-1];
      assign st_b[k]   = b_q[k-1];
      assign st_s[k]   = s_q[k-1];
    end

    rca_pipe_stage #(.SEG(SEG)) u_seg (
      .a       (st_a[k][k*SEG +: SEG]),
      .b       (st_b[k][k*SEG +: SEG]),
      .cin     (st_cin[k]),
      .s       (seg_s[k]),
      .cout    (seg_co[k]),
      .cin_msb (seg_cmsb[k])
    );
  end

  // Next-state: shift every stage forward on advance, otherwise hold.
  always_comb begin
    vld_d = vld_q;
    sub_d = sub_q;
    cy_d  = cy_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    flg_d = flg_q;
    if (adv) begin
      vld_d = st_vld;
      sub_d = st_sub;
      cy_d  = seg_co;
      a_d   = st_a;
      b_d   = st_b;
      s_d   = st_s;
      for (int k = 0; k < STAGES; k++) s_d[k][k*SEG +: SEG] = seg_s[k];
      flg_d.c_out = seg_co[STAGES-1];
      flg_d.ovf   = seg_cmsb[STAGES-1] ^ seg_co[STAGES-1];
      flg_d.zero  = (s_d[STAGES-1] == '0);
    end
  end

  // Stage registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      sub_q <= '0;
      cy_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      flg_q <= '0;
    end else begin
      vld_q <= vld_d;
      sub_q <= sub_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      flg_q <= flg_d;
    end
  end

  // Skew bits already consumed and last-stage leftovers have no reader.
  assign unused_bits = ^{st_a, st_b, st_s, a_q[STAGES-1], b_q[STAGES-1],
                         sub_q[STAGES-1], cy_q[STAGES-1], seg_cmsb};

endmodule

// File: tb/tb_rca_pipelined.sv
// Directed and streaming bench for the pipelined adder (32/4 and 8/1).
module tb_rca_pipelined;
  localparam int W  = 32;
  localparam int ST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf, zero;
  logic [W-1:0] a, b, sum;
  logic iv8, ir8, cin8, sub8, ov8, or8, co8, ovf8, z8;
  logic [7:0] a8, b8, s8;

  rca_pipelined #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf), .zero(zero));

  rca_pipelined #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .c_in(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .c_out(co8), .ovf(ovf8), .zero(z8));

  typedef struct {logic [W-1:0] s; logic c, v, z;} res_t;
  typedef struct {logic [7:0] s; logic c, v, z;} r8_t;
  typedef struct {logic [W-1:0] a, b; logic ci, sb; logic [W-1:0] es; logic ec, ev, ez;} vec_t;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference: two's-complement add with a 33-bit sum; overflow from operand signs.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    res_t r;
    logic [W-1:0] yy;
    logic [W:0] t;
    yy = sb ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb | ci)};
    r.s = t[W-1:0];
    r.c = t[W];
    r.v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    r.z = (t[W-1:0] == '0);
    return r;
  endfunction

  function automatic r8_t model8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
    r8_t r;
    logic [7:0] yy;
    logic [8:0] t;
    yy = sb ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {8'b0, (sb | ci)};
    r.s = t[7:0];
    r.c = t[8];
    r.v = (x[7] == yy[7]) && (t[7] != x[7]);
    r.z = (t[7:0] == 8'h00);
    return r;
  endfunction

  // Streaming scoreboard for the 32/4 instance.
  logic mon_en = 1'b0, held_ok = 1'b0;
  res_t expq[$];
  res_t e, held;
  int out_cnt = 0, first_cyc = 0, last_cyc = 0, stall_seen = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && held_ok) begin
        chk("hold_sum", sum, held.s);
        chk1("hold_cout", c_out, held.c);
        chk1("hold_ovf", ovf, held.v);
      end
      chk1("in_ready", in_ready, out_ready | ~out_valid);
      if (!in_ready) stall_seen++;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra: got beat %h expected none", sum);
        end else begin
          e = expq.pop_front();
          chk("stream_sum", sum, e.s);
          chk1("stream_cout", c_out, e.c);
          chk1("stream_ovf", ovf, e.v);
          chk1("stream_zero", zero, e.z);
        end
        if (out_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
        held_ok = 1'b0;
      end else if (out_valid) begin
        held_ok = 1'b1;
        held.s = sum; held.c = c_out; held.v = ovf; held.z = zero;
      end else begin
        held_ok = 1'b0;
      end
      if (in_valid && in_ready) expq.push_back(model(a, b, c_in, sub));
    end
  end

  // Scoreboard for the 8/1 instance; also checks single-cycle latency.
  logic mon8_en = 1'b0, prev_iv8 = 1'b0;
  r8_t q8[$];
  r8_t e8;
  int cnt8 = 0, sent8 = 0;

  always @(negedge clk) begin
    if (mon8_en) begin
      chk1("lat8_valid", ov8, prev_iv8);
      if (ov8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL w8_extra: got beat %h expected none", s8);
        end else begin
          e8 = q8.pop_front();
          chk("w8_sum", {24'b0, s8}, {24'b0, e8.s});
          chk1("w8_cout", co8, e8.c);
          chk1("w8_ovf", ovf8, e8.v);
          chk1("w8_zero", z8, e8.z);
        end
        cnt8++;
      end
      if (iv8 && ir8) begin
        q8.push_back(model8(a8, b8, cin8, sub8));
        sent8++;
      end
      prev_iv8 = iv8 & ir8;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    int n;
    in_valid = 1'b1; a = x; b = y; c_in = ci; sub = sb;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    in_valid = 1'b1; a = v.a; b = v.b; c_in = v.ci; sub = v.sb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk1($sformatf("vec%0d_early", idx), out_valid, 1'b0);
    @(negedge clk);
    chk1($sformatf("vec%0d_valid", idx), out_valid, 1'b1);
    chk($sformatf("vec%0d_sum", idx), sum, v.es);
    chk1($sformatf("vec%0d_cout", idx), c_out, v.ec);
    chk1($sformatf("vec%0d_ovf", idx), ovf, v.ev);
    chk1($sformatf("vec%0d_zero", idx), zero, v.ez);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
    rst_n = 1'b0;

    // Reset held with a valid beat on the input: nothing may come out.
    in_valid = 1'b1; a = 32'd1; b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk1($sformatf("post_rst_valid_%0d", i), out_valid, (i == 4));
    end
    chk("post_rst_sum", sum, 32'd3);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Reset while two beats are in flight: both must vanish.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'h10; b = 32'h20;
    @(posedge clk); #1;
    a = 32'h30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("midrst_valid", out_valid, 1'b0);
    end

    // Back-to-back streaming, one result per cycle.
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    repeat (ST + 2) @(posedge clk);
    #1;
    chk("stream_count", out_cnt, 32'd100);
    chk("stream_span", last_cyc - first_cyc, 32'd99);
    chk("stream_leftover", expq.size(), 32'd0);

    // Stall the output mid-stream for 6 cycles.
    out_cnt = 0; stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (ST + 2) @(posedge clk);
    #1;
    chk("bp_count", out_cnt, 32'd30);
    chk("bp_leftover", expq.size(), 32'd0);
    chk1("bp_stalled", stall_seen > 0, 1'b1);
    mon_en = 1'b0;

    // 8-bit single-stage instance: random beats with random bubbles.
    mon8_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
      iv8 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w8_count", cnt8, sent8);
    chk("w8_leftover", q8.size(), 32'd0);
    mon8_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
